// File: rtl/mtm_alu_deserializer_if.sv
// Serial-link bundle between the MTM tester (master) and the ALU input deserializer (slave).
// Also carries the deserializer FSM state so checkers can bind to it.
interface mtm_alu_deserializer_if #(
    parameter int DATA_W = 32
);
    logic              sin;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [2:0]        op_out;
    logic              pkt_valid;
    logic              err_valid;
    logic [2:0]        err_flags;
    logic [2:0]        dbg_state;

    // Strobe semantics: pkt_valid / err_valid are single-cycle, mutually exclusive,
    // with no back-pressure; the consumer must take them in the cycle they appear.
    modport master (
        output sin,
        input  a_out, b_out, op_out, pkt_valid, err_valid, err_flags, dbg_state
    );

    modport slave (
        input  sin,
        output a_out, b_out, op_out, pkt_valid, err_valid, err_flags, dbg_state
    );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// MTM ALU serial-link deserializer: recovers 11-bit frames from sin, assembles {B,A,op},
// verifies CRC-4 and opcode, and issues a packet-valid or error strobe to the ALU core.
module mtm_alu_deserializer #(
    parameter int         DATA_W   = 32,
    parameter int         N_FRAMES = 8,
    parameter logic [3:0] CRC_INIT = 4'h0
) (
    input logic                   clk,
    input logic                   rst,
    mtm_alu_deserializer_if.slave bus
);

    localparam int SHIFT_W = 2 * DATA_W;
    localparam int CNT_W   = $clog2(N_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_FRAMES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TYPE  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam logic [2:0] FLAG_DATA = 3'b100;
    localparam logic [2:0] FLAG_CRC  = 3'b010;
    localparam logic [2:0] FLAG_OP   = 3'b001;

    logic [2:0]         r_state;
    logic               r_type;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_byte;
    logic [SHIFT_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_drop;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [2:0]         r_op;
    logic               r_pkt_valid;
    logic               r_err_valid;
    logic [2:0]         r_err_flags;

    logic [2:0]         w_op;
    logic [3:0]         w_crc;
    logic               w_crc_ok;
    logic               w_op_ok;
    logic               w_full;

    // Serial CRC-4 (x^4+x+1) unrolled over the whole message; flattens to XOR trees.
    function automatic logic [3:0] crc4(input logic [SHIFT_W+3:0] msg);
        logic [3:0] c;
        logic       fb;
        c = CRC_INIT;
        for (int i = SHIFT_W + 3; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2], c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    always_comb begin
        w_op     = r_byte[6:4];
        w_crc    = crc4({r_shift, 1'b1, w_op});
        w_crc_ok = (w_crc == r_byte[3:0]);
        w_op_ok  = (w_op == 3'b000) || (w_op == 3'b001) ||
                   (w_op == 3'b100) || (w_op == 3'b101);
        w_full   = (r_cnt == CNT_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_type      <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_byte      <= 8'h00;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_drop      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 3'b000;
            r_pkt_valid <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_flags <= 3'b000;
        end else begin
            r_pkt_valid <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_flags <= 3'b000;
            case (r_state)
                S_IDLE: begin
                    if (!bus.sin) r_state <= S_TYPE;
                end
                S_TYPE: begin
                    r_type    <= bus.sin;
                    r_bit_cnt <= 3'd0;
                    r_state   <= S_DATA;
                end
                S_DATA: begin
                    r_byte    <= {r_byte[6:0], bus.sin};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) r_state <= S_STOP;
                end
                S_STOP: begin
                    r_state <= S_IDLE;
                    if (!bus.sin) begin
                        r_err_valid <= 1'b1;
                        r_err_flags <= FLAG_DATA;
                        r_cnt       <= '0;
                        r_state     <= S_FLUSH;
                    end else if (!r_type) begin
                        // While dropping after an overrun, data frames are discarded.
                        if (!r_drop) begin
                            if (w_full) begin
                                r_err_valid <= 1'b1;
                                r_err_flags <= FLAG_DATA;
                                r_cnt       <= '0;
                                r_drop      <= 1'b1;
                            end else begin
                                r_shift <= {r_shift[SHIFT_W-9:0], r_byte};
                                r_cnt   <= r_cnt + 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= '0;
                        if (r_drop) begin
                            r_drop <= 1'b0;
                        end else if (r_byte[7] || !w_full) begin
                            r_err_valid <= 1'b1;
                            r_err_flags <= FLAG_DATA;
                        end else if (!w_crc_ok) begin
                            r_err_valid <= 1'b1;
                            r_err_flags <= FLAG_CRC;
                        end else if (!w_op_ok) begin
                            r_err_valid <= 1'b1;
                            r_err_flags <= FLAG_OP;
                        end else begin
                            r_pkt_valid <= 1'b1;
                            r_b         <= r_shift[SHIFT_W-1:DATA_W];
                            r_a         <= r_shift[DATA_W-1:0];
                            r_op        <= w_op;
                        end
                    end
                end
                S_FLUSH: begin
                    if (bus.sin) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.a_out     = r_a;
    assign bus.b_out     = r_b;
    assign bus.op_out    = r_op;
    assign bus.pkt_valid = r_pkt_valid;
    assign bus.err_valid = r_err_valid;
    assign bus.err_flags = r_err_flags;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed and random frame-level stimulus for the MTM ALU deserializer, with an event
// scoreboard of pkt/err strobes and their held operand values.
module tb_mtm_alu_deserializer;

    logic clk;
    logic rst;

    mtm_alu_deserializer_if #(.DATA_W(32)) bus ();

    mtm_alu_deserializer #(
        .DATA_W   (32),
        .N_FRAMES (8),
        .CRC_INIT (4'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Event word: {pkt, err, flags, op, b, a}
    logic [71:0] exp_q[$];
    logic [71:0] obs_q[$];

    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;
    logic [2:0]  last_op = 3'b000;

    always @(negedge clk) begin
        if (bus.pkt_valid || bus.err_valid)
            obs_q.push_back({bus.pkt_valid, bus.err_valid,
                             (bus.err_valid ? bus.err_flags : 3'b000),
                             bus.op_out, bus.b_out, bus.a_out});
    end

    // Reference CRC by polynomial long division of {B,A,1,op}*x^4 by 10011.
    function automatic logic [3:0] crc_model(input logic [31:0] b, input logic [31:0] a,
                                             input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.sin = 1'b1;
        end
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        @(negedge clk);
        bus.sin = 1'b0;
        @(negedge clk);
        bus.sin = typ;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bus.sin = d[i];
        end
        @(negedge clk);
        bus.sin = stop;
    endtask

    task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                               input logic [3:0] crc, input logic d7, input int n_data);
        logic [63:0] ba;
        ba = {b, a};
        for (int i = 0; i < n_data; i++) begin
            if (i < 8) send_frame(1'b0, ba[63 - 8*i -: 8], 1'b1);
            else       send_frame(1'b0, 8'h5A, 1'b1);
        end
        send_frame(1'b1, {d7, op, crc}, 1'b1);
    endtask

    task automatic expect_pkt(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
        exp_q.push_back({2'b10, 3'b000, op, b, a});
        last_a  = a;
        last_b  = b;
        last_op = op;
    endtask

    task automatic expect_err(input logic [2:0] flags);
        exp_q.push_back({2'b01, flags, last_op, last_b, last_a});
    endtask

    task automatic drain(input string tag);
        idle(3);
        check({tag, "_count"}, 72'(obs_q.size()), 72'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_event"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] rb, ra;
        logic [2:0]  rop;
        logic [3:0]  rcrc;
        logic        corrupt;

        rst     = 1'b1;
        bus.sin = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {bus.pkt_valid, bus.err_valid, bus.err_flags, bus.op_out, bus.b_out, bus.a_out}, 72'h0);
        check("reset_state", 72'(bus.dbg_state), 72'h0);
        idle(2);

        // T1: valid ADD, strobe exactly one cycle after the cmd stop bit
        send_packet(32'h0000_0002, 32'h0000_0003, 3'b100,
                    crc_model(32'h0000_0002, 32'h0000_0003, 3'b100), 1'b0, 8);
        @(negedge clk);
        bus.sin = 1'b1;
        check("t1_latency_pkt", 72'(bus.pkt_valid), 72'h1);
        check("t1_a_out", 72'(bus.a_out), 72'h3);
        check("t1_b_out", 72'(bus.b_out), 72'h2);
        check("t1_op_out", 72'(bus.op_out), 72'h4);
        @(negedge clk);
        check("t1_strobe_width", 72'(bus.pkt_valid), 72'h0);
        expect_pkt(32'h0000_0002, 32'h0000_0003, 3'b100);
        drain("t1");

        // T2: short packet (7 data frames)
        send_packet(32'h0000_0002, 32'h0000_0003, 3'b100,
                    crc_model(32'h0000_0002, 32'h0000_0003, 3'b100), 1'b0, 7);
        expect_err(3'b100);
        drain("t2");

        // T3: CRC bit 0 inverted
        send_packet(32'h0000_0002, 32'h0000_0003, 3'b100,
                    crc_model(32'h0000_0002, 32'h0000_0003, 3'b100) ^ 4'b0001, 1'b0, 8);
        expect_err(3'b010);
        drain("t3");

        // T4: illegal opcode with correct CRC
        send_packet(32'h1111_2222, 32'h3333_4444, 3'b011,
                    crc_model(32'h1111_2222, 32'h3333_4444, 3'b011), 1'b0, 8);
        expect_err(3'b001);
        drain("t4");

        // T5: stop error, sin low 5 clks, then a full valid SUB packet
        send_frame(1'b0, 8'hA5, 1'b0);
        repeat (5) @(negedge clk);
        bus.sin = 1'b1;
        expect_err(3'b100);
        send_packet(32'hDEAD_BEEF, 32'h1234_5678, 3'b101,
                    crc_model(32'hDEAD_BEEF, 32'h1234_5678, 3'b101), 1'b0, 8);
        expect_pkt(32'hDEAD_BEEF, 32'h1234_5678, 3'b101);
        drain("t5");

        // T6: reset after 4 data frames, then a full valid AND packet
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'hC3, 1'b1);
        @(negedge clk);
        rst     = 1'b1;
        bus.sin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t6_reset_a_out", 72'(bus.a_out), 72'h0);
        check("t6_reset_state", 72'(bus.dbg_state), 72'h0);
        last_a = 32'h0; last_b = 32'h0; last_op = 3'b000;
        send_packet(32'h0000_FFFF, 32'h8000_0000, 3'b000,
                    crc_model(32'h0000_FFFF, 32'h8000_0000, 3'b000), 1'b0, 8);
        expect_pkt(32'h0000_FFFF, 32'h8000_0000, 3'b000);
        drain("t6");

        // T7: overrun (9 data frames); the following cmd is swallowed, next packet is good
        send_packet(32'h0101_0101, 32'h0202_0202, 3'b001,
                    crc_model(32'h0101_0101, 32'h0202_0202, 3'b001), 1'b0, 9);
        expect_err(3'b100);
        send_packet(32'hCAFE_0001, 32'h0000_00FF, 3'b001,
                    crc_model(32'hCAFE_0001, 32'h0000_00FF, 3'b001), 1'b0, 8);
        expect_pkt(32'hCAFE_0001, 32'h0000_00FF, 3'b001);
        drain("t7");

        // T8: cmd byte with d[7]=1 wins over a correct CRC and op
        send_packet(32'h5555_AAAA, 32'h0F0F_F0F0, 3'b100,
                    crc_model(32'h5555_AAAA, 32'h0F0F_F0F0, 3'b100), 1'b1, 8);
        expect_err(3'b100);
        drain("t8");

        // T9: back-to-back random packets
        for (int k = 0; k < 200; k++) begin
            rb      = $urandom;
            ra      = $urandom;
            rop     = 3'($urandom_range(0, 7));
            corrupt = ($urandom_range(0, 9) == 0);
            rcrc    = crc_model(rb, ra, rop);
            if (corrupt) rcrc = rcrc ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) begin
                for (int i = 0; i < 4; i++) send_frame(1'b0, 8'h3C, 1'b1);
                @(negedge clk);
                rst     = 1'b1;
                bus.sin = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                last_a = 32'h0; last_b = 32'h0; last_op = 3'b000;
            end else begin
                send_packet(rb, ra, rop, rcrc, 1'b0, 8);
                if (corrupt)
                    expect_err(3'b010);
                else if (!(rop == 3'b000 || rop == 3'b001 || rop == 3'b100 || rop == 3'b101))
                    expect_err(3'b001);
                else
                    expect_pkt(rb, ra, rop);
            end
        end
        drain("t9_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
